// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- arbitrates NUM_REQ byte-stream requesters onto the AXI4-Lite
// write port of a UART Lite core (TX FIFO at offset 0x4).
//
// Arbitration is round-robin between packets: a requester that is accepted with
// req_last=0 keeps ownership (lock) until it delivers a byte with req_last=1,
// after which the round-robin pointer moves to the next requester. One byte is
// in flight at a time: IDLE -> WRITE (AW+W) -> RESP (B) -> IDLE.
//
// Optional feature (macro UART_TX_ARB_POLL_EN): before each write the status
// register (offset 0x8) is read and the write waits while rdata[3] (TX FIFO
// full) is set. With the macro undefined the read channel is tied off.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_data/req_last  per-requester byte stream (byte i at [8i+7:8i])
//   req_ready                    one-cycle accept strobe per requester
//   grant                        one-hot current owner (in-flight or locked)
//   busy                         high whenever the FSM is not IDLE
//   err_cnt                      saturating count of non-OKAY write responses
//   aw*/w*/b*                    AXI4-Lite write channels to the UART Lite
//   ar*/r*                       AXI4-Lite read channels (status polling)
module uart_tx_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           err_cnt,
  output logic [3:0]           awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [7:0]           wdata,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [3:0]           araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [7:0]           rdata,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef UART_TX_ARB_POLL_EN
  typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, WRITE, RESP} state_t;
  localparam state_t AFTER_ACCEPT = POLL_AR;
  logic unused_rd;
  assign unused_rd = ^{rdata[7:4], rdata[2:0]};
`else
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
  localparam state_t AFTER_ACCEPT = WRITE;
  logic unused_rd;
  assign unused_rd = ^{arready, rdata, rvalid};
`endif

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, lock_idx, own_idx, sel_idx;
  logic               lock_vld, sel_vld, accept;
  logic [7:0]         data_q;
  logic               aw_done, w_done;

  // Eligible requester: the locked one only, otherwise the first valid one
  // at or above the round-robin pointer (wrapping).
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    if (lock_vld) begin
      sel_vld = req_valid[lock_idx];
      sel_idx = lock_idx;
    end else begin
      // Walk downwards so the nearest candidate to rr_ptr is written last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
          sel_vld = 1'b1;
          sel_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves a signal unassigned and infers a latch.
    state_nxt = state;
    req_ready = '0;
    grant     = '0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    awaddr    = '0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    araddr    = '0;
    rready    = 1'b0;
    if (state != IDLE) grant[own_idx] = 1'b1;
    case (state)
      IDLE: begin
        // rst gating keeps the combinational accept quiet while reset is held.
        if (!rst && sel_vld) begin
          req_ready[sel_idx] = 1'b1;
          grant[sel_idx]     = 1'b1;
          state_nxt          = AFTER_ACCEPT;
        end else if (!rst && lock_vld) begin
          grant[lock_idx] = 1'b1;
        end
      end
`ifdef UART_TX_ARB_POLL_EN
      POLL_AR: begin
        arvalid = 1'b1;
        araddr  = 4'h8;
        if (arready) state_nxt = POLL_R;
      end
      POLL_R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = rdata[3] ? POLL_AR : WRITE;
      end
`endif
      WRITE: begin
        awaddr  = 4'h4;
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = |req_ready;
  assign busy   = (state != IDLE);
  assign wdata  = data_q;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      own_idx  <= '0;
      data_q   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (accept) begin
        own_idx <= sel_idx;
        data_q  <= req_data[{sel_idx, 3'b000} +: 8];
        if (req_last[sel_idx]) begin
          lock_vld <= 1'b0;
          rr_ptr   <= IDX_W'((int'(sel_idx) + 1) % NUM_REQ);
        end else begin
          lock_vld <= 1'b1;
          lock_idx <= sel_idx;
        end
      end
      if (state == WRITE) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
        if (state_nxt == RESP) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
      end
      // A failed byte is only counted, never retried.
      if (state == RESP && bvalid && bresp != 2'b00 && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb -- scoreboard bench for uart_tx_arb (NUM_REQ=2).
// A driver process feeds per-requester byte queues and an AXI slave model and
// predicts, at each accept, the winning requester and the byte that must later
// appear on W. A separate monitor pops those bytes and checks channel rules.
module tb_uart_tx_arb;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           busy;
  logic [7:0]     err_cnt, wdata, rdata;
  logic [3:0]     awaddr, araddr;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready;
  logic [1:0]     bresp;

  uart_tx_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy), .err_cnt(err_cnt),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  int errors = 0;
  int checks = 0;

  beat_t      req_q [N][$];
  logic [7:0] exp_q [$];

  // Reference model of the arbiter (packet-level round robin).
  int m_rr = 0, m_lock_i = 0, owner = 0, m_err = 0;
  bit m_lock = 0, inflight = 0;
  int first_acc = -1;
  bit track_first = 0;

  // Slave knobs and state.
  int ready_pct = 100, b_dly_max = 0, b_dly_min = 0, err_pct = 0, gap_pct = 0;
  bit aw_got = 0, w_got = 0, b_pend = 0;
  int b_wait = 0;
  logic [1:0] b_resp_q = 2'b00;
`ifdef UART_TX_ARB_POLL_EN
  logic [7:0] rd_q [$];
  bit r_pend = 0, last_full = 0;
  int reads_txn = 0, last_reads = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    if (m_lock) return v[m_lock_i] ? m_lock_i : -1;
    for (int k = 0; k < N; k++)
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return (i < 0) ? '0 : (N'(1) << i);
  endfunction

  function automatic int pending();
    int p = exp_q.size() + int'(inflight);
    for (int i = 0; i < N; i++) p += req_q[i].size();
    return p;
  endfunction

  task automatic push_beat(input int r, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    req_q[r].push_back(b);
  endtask

  task automatic wait_drain(input int max_cyc);
    int c = 0;
    while (pending() != 0) begin
      @(negedge clk);
      c++;
      if (c >= max_cyc) begin
        check("drain_timeout", pending(), 0);
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_valids"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
    check({tag, "_addr_data"}, {awaddr, araddr, wdata}, 0);
  endtask

  // Driver: requester streams, AXI slave, and arbitration prediction.
  initial begin : drv
    int exp_i;
    logic [N-1:0] exp_g;
    beat_t b;
    req_valid = '0; req_data = '0; req_last = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = req_q[i][0].data;
          req_last[i]        = req_q[i][0].last;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'($urandom);
          req_last[i]        = 1'($urandom);
        end
      end
      awready = ($urandom_range(99) < ready_pct);
      wready  = ($urandom_range(99) < ready_pct);
      if (!b_pend) begin
        bvalid = 1'b0;
        bresp  = 2'($urandom);
      end else if (!bvalid) begin
        if (b_wait == 0) begin
          bvalid = 1'b1;
          bresp  = b_resp_q;
        end else b_wait--;
      end
`ifdef UART_TX_ARB_POLL_EN
      arready = ($urandom_range(99) < ready_pct);
      if (!r_pend) rvalid = 1'b0;
      else if (!rvalid) begin
        logic [7:0] rd;
        rd = 8'($urandom);
        if (rd_q.size() > 0) rd = rd_q.pop_front();
        else rd[3] = ($urandom_range(3) == 0);
        rvalid = 1'b1;
        rdata  = rd;
      end
`else
      arready = 1'($urandom);
      rvalid  = 1'($urandom);
      rdata   = 8'($urandom);
`endif
      @(negedge clk); #4;
      if (rst) begin
        m_rr = 0; m_lock = 0; inflight = 0;
        aw_got = 0; w_got = 0; b_pend = 0;
`ifdef UART_TX_ARB_POLL_EN
        r_pend = 0; reads_txn = 0;
`endif
      end else begin
        exp_i = inflight ? -1 : pick(req_valid);
        check("busy", busy, inflight);
        check("req_ready", req_ready, onehot(exp_i));
        if (inflight)       exp_g = onehot(owner);
        else if (exp_i >= 0) exp_g = onehot(exp_i);
        else if (m_lock)    exp_g = onehot(m_lock_i);
        else                exp_g = '0;
        check("grant", grant, exp_g);
        if (exp_i >= 0) begin
          b = req_q[exp_i].pop_front();
          exp_q.push_back(b.data);
          if (b.last) begin
            m_lock = 0;
            m_rr   = (exp_i + 1) % N;
          end else begin
            m_lock   = 1;
            m_lock_i = exp_i;
          end
          inflight = 1;
          owner    = exp_i;
          if (track_first) begin
            first_acc   = exp_i;
            track_first = 0;
          end
        end
        if (bvalid && bready) begin
          b_pend   = 0;
          inflight = 0;
        end
        if (awvalid && awready) begin
          aw_got = 1;
`ifdef UART_TX_ARB_POLL_EN
          check("poll_before_write", {reads_txn != 0, last_full}, 2'b10);
          last_reads = reads_txn;
          reads_txn  = 0;
`endif
        end
        if (wvalid && wready) w_got = 1;
        if (aw_got && w_got && !b_pend) begin
          b_pend   = 1;
          aw_got   = 0;
          w_got    = 0;
          b_wait   = b_dly_min + $urandom_range(b_dly_max);
          b_resp_q = ($urandom_range(99) < err_pct) ? 2'b10 : 2'b00;
        end
`ifdef UART_TX_ARB_POLL_EN
        if (rvalid && rready) begin
          r_pend    = 0;
          reads_txn++;
          last_full = rdata[3];
        end
        if (arvalid && arready) r_pend = 1;
`endif
      end
    end
  end

  // Monitor: scoreboard for W data plus AXI channel rules.
  initial begin : mon
    bit acc_prev, aw_pend_prev, w_pend_prev, aw_hs_prev, w_hs_prev, b_hs_prev;
    logic [3:0] awaddr_prev;
    logic [7:0] wdata_prev;
    acc_prev = 0; aw_pend_prev = 0; w_pend_prev = 0;
    aw_hs_prev = 0; w_hs_prev = 0; b_hs_prev = 0;
    awaddr_prev = '0; wdata_prev = '0;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        exp_q.delete();
        m_err = 0;
        acc_prev = 0; aw_pend_prev = 0; w_pend_prev = 0;
        aw_hs_prev = 0; w_hs_prev = 0; b_hs_prev = 0;
      end else begin
        check("err_cnt", err_cnt, m_err);
`ifdef UART_TX_ARB_POLL_EN
        if (arvalid) check("araddr", araddr, 4'h8);
`else
        check("read_tied_off", {arvalid, rready, araddr}, 0);
        if (acc_prev) check("write_latency", {awvalid, wvalid}, 2'b11);
`endif
        if (aw_pend_prev) check("aw_stable", {awvalid, awaddr}, {1'b1, awaddr_prev});
        if (w_pend_prev)  check("w_stable", {wvalid, wdata}, {1'b1, wdata_prev});
        if (aw_hs_prev)   check("aw_drop", awvalid, 0);
        if (w_hs_prev)    check("w_drop", wvalid, 0);
        if (b_hs_prev)    check("idle_after_b", busy, 0);
        if (awvalid && awready) check("awaddr", awaddr, 4'h4);
        if (wvalid && wready) begin
          check("write_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("wdata", wdata, exp_q.pop_front());
        end
        if (bvalid && bready && bresp != 2'b00 && m_err < 255) m_err++;
        acc_prev     = |req_ready;
        aw_pend_prev = awvalid && !awready;
        w_pend_prev  = wvalid && !wready;
        aw_hs_prev   = awvalid && awready;
        w_hs_prev    = wvalid && wready;
        b_hs_prev    = bvalid && bready;
        awaddr_prev  = awaddr;
        wdata_prev   = wdata;
      end
    end
  end

  initial begin : main
    int c;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // Byte waiting during reset must not be accepted until reset is gone.
    push_beat(0, 8'h41, 1'b1);
    @(posedge clk); #2;
    check("rst_req_valid_seen", req_valid[0], 1);
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    wait_drain(200);

    // Both requesters always valid, single-byte packets: alternate.
    for (int k = 0; k < 4; k++) begin
      push_beat(0, 8'h10 + 8'(k), 1'b1);
      push_beat(1, 8'h20 + 8'(k), 1'b1);
    end
    wait_drain(400);

    // Three-byte packet on req0 with req1 valid throughout: lock holds.
    push_beat(0, 8'hA0, 1'b0);
    push_beat(0, 8'hA1, 1'b0);
    push_beat(0, 8'hA2, 1'b1);
    push_beat(1, 8'hB0, 1'b1);
    push_beat(1, 8'hB1, 1'b1);
    wait_drain(400);

`ifdef UART_TX_ARB_POLL_EN
    rd_q.push_back(8'h08);
    rd_q.push_back(8'h08);
    rd_q.push_back(8'h00);
    push_beat(0, 8'h55, 1'b1);
    wait_drain(400);
    check("poll_reads", last_reads, 3);
`endif

    // Two error responses.
    err_pct = 100;
    push_beat(1, 8'hE0, 1'b1);
    push_beat(1, 8'hE1, 1'b1);
    wait_drain(400);
    check("err_after_2", err_cnt, 2);

    // Randomized traffic: packet lengths, gaps, back-pressure, responses.
    ready_pct = 60; b_dly_max = 3; err_pct = 25; gap_pct = 20;
    for (int p = 0; p < 150; p++) begin
      int r, len;
      r   = $urandom_range(N - 1);
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) push_beat(r, 8'($urandom), j == len - 1);
      if (p % 8 == 7) wait_drain(2000);
    end
    wait_drain(2000);

    // 300 error writes saturate the counter.
    ready_pct = 100; b_dly_max = 0; err_pct = 100; gap_pct = 0;
    for (int k = 0; k < 300; k++) push_beat(k % 2, 8'(k), 1'b1);
    wait_drain(5000);
    check("err_saturated", err_cnt, 255);

    // Reset while waiting for a write response.
    err_pct = 0; b_dly_min = 3;
    push_beat(0, 8'h77, 1'b1);
    push_beat(0, 8'h78, 1'b1);
    push_beat(1, 8'h79, 1'b1);
    push_beat(1, 8'h7A, 1'b1);
    c = 0;
    while (!bready && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("resp_reached", bready, 1);
    #1 rst = 1'b1;
    #1 check_all_zero("rst_in_resp");
    b_dly_min = 0;
    track_first = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(400);
    check("first_after_rst", first_acc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 2, number of byte-stream requesters (legal 2..4).
REQ-002 SHALL provide clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide req_valid  input  NUM_REQ  per-requester byte available.
REQ-005 SHALL provide req_data  input  8*NUM_REQ  per-requester byte, requester i at bits [8i+7:8i].
REQ-006 SHALL provide req_last  input  NUM_REQ  byte is final byte of requester's packet.
REQ-007 SHALL provide req_ready  output  NUM_REQ  one-cycle accept strobe per requester.
REQ-008 SHALL provide grant  output  NUM_REQ  one-hot current owner, 0 when no owner.
REQ-009 SHALL provide busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL provide err_cnt  output  8  saturating count of non-OKAY write responses.
REQ-011 SHALL provide awaddr/awvalid (out 4/1), awready (in 1)  AXI4-Lite write address to UART Lite.
REQ-012 SHALL provide wdata/wvalid (out 8/1), wready (in 1)  AXI4-Lite write data.
REQ-013 SHALL provide bresp/bvalid (in 2/1), bready (out 1)  AXI4-Lite write response.
REQ-014 SHALL provide araddr/arvalid (out 4/1), arready, rdata[7:0], rvalid (in), rready (out)  AXI4-Lite read channel.

Function
REQ-015 States: IDLE, POLL_AR, POLL_R, WRITE, RESP; POLL_* exist only per REQ-030.
REQ-016 IDLE, no lock: select first i with req_valid[i]=1 searching from rr pointer upward mod NUM_REQ; assert req_ready[i] combinationally that cycle; capture req_data[i] and req_last[i].
REQ-017 IDLE, lock held: only locked requester eligible; other req_valid ignored.
REQ-018 Accept with req_last=0 sets lock to that requester; accept with req_last=1 clears lock and sets rr pointer to (i+1) mod NUM_REQ.
REQ-019 At most one req_ready bit high per cycle; req_ready is 0 outside IDLE.
REQ-020 grant = one-hot of in-flight or locked requester, held from accept cycle through RESP and while locked.
REQ-021 WRITE: awaddr=4'h4 (TX FIFO), wdata=captured byte, awvalid and wvalid asserted together; each drops independently the cycle after its handshake; exit to RESP once both complete (same cycle allowed).
REQ-022 Without polling, awvalid/wvalid rise the cycle after accept (latency 1).
REQ-023 Valid outputs and awaddr/wdata SHALL stay stable until handshake.
REQ-024 RESP: bready=1; on bvalid return to IDLE next cycle; bresp!=2'b00 increments err_cnt, saturating at 255; byte not retried.
REQ-025 Earliest next accept: cycle after bvalid handshake.
REQ-026 busy=0 only in IDLE.

Reset
REQ-027 rst SHALL immediately force IDLE, all AXI valid/ready outputs 0, awaddr/araddr/wdata 0, req_ready 0, grant 0, err_cnt 0, lock cleared, rr pointer 0.
REQ-028 Reset mid-transaction SHALL drop the in-flight byte with no further AXI activity.
REQ-029 After rst deassertion, first accept occurs no earlier than the following clk edge.

Configuration
REQ-030 Macro UART_TX_ARB_POLL_EN defined: after accept go POLL_AR (araddr=4'h8, arvalid until arready), then POLL_R (rready=1); on rvalid, rdata[3]=1 (TX FIFO full) returns to POLL_AR, else WRITE.
REQ-031 Macro undefined: accept goes directly to WRITE; arvalid, rready, araddr tied 0; read inputs ignored.

Verification
REQ-032 req0 byte 0x41 last=1, slave ready immediately -> req_ready[0] one-cycle pulse, next cycle awaddr=0x4 wdata=0x41, busy low cycle after bvalid.
REQ-033 req0,req1 always valid, last=1 -> accept order 0,1,0,1; grant alternates.
REQ-034 req0 3-byte packet (last on 3rd), req1 valid throughout -> 3 req0 accepts then req1.
REQ-035 bresp=2'b10 on 2 writes -> err_cnt=2; 300 error writes -> err_cnt=255.
REQ-036 POLL_EN, rdata=0x08,0x08,0x00 -> 3 reads then one write.
REQ-037 rst asserted in RESP -> all outputs 0 same cycle; next accept from req0.
